// File: rtl/arb_pkg.sv
// Shared types for the instruction/data memory port arbiter: FSM states, grant IDs
// and the sizing helper for the timeout counter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    // Bits needed to hold 0..timeout; a disabled timeout still gets a 1-bit counter.
    function automatic int tmo_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter view,
// master = core/memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_done;
    logic                  d_req;
    logic                  d_we;
    logic [DATA_W/8-1:0]   d_be;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_done;
    logic                  stall_if;
    logic                  stall_d;
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_ready;
    logic                  err;
    logic                  err_src;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_done, d_rdata, d_done, stall_if, stall_d,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, err, err_src
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_done, d_rdata, d_done, stall_if, stall_d,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, err, err_src
    );

endinterface

// File: rtl/arb_perf_counters.sv
// Wrapping 32-bit counters of completed fetch/data accesses and of stalled cycles.
module arb_perf_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_if_done,
    input  logic        i_d_done,
    input  logic        i_stall,
    output logic [31:0] o_if_cnt,
    output logic [31:0] o_d_cnt,
    output logic [31:0] o_stall_cnt
);
    logic [31:0] r_if_cnt;
    logic [31:0] r_d_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_cnt    <= '0;
            r_d_cnt     <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (i_if_done) r_if_cnt    <= r_if_cnt + 32'd1;
            if (i_d_done)  r_d_cnt     <= r_d_cnt + 32'd1;
            if (i_stall)   r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_if_cnt    = r_if_cnt;
    assign o_d_cnt     = r_d_cnt;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and load/store, one access
// outstanding, with timeout abort. Define ARB_PERF_CNT_EN to add the performance counter ports.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
   ,output logic [31:0]         perf_if_cnt,
    output logic [31:0]         perf_d_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);
    localparam int BE_W  = DATA_W / 8;
    localparam int TMO_W = tmo_width(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic                r_last_grant;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [BE_W-1:0]     r_mem_be;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_if_done;
    logic                r_d_done;
    logic                r_err;
    logic                r_err_src;

    logic                w_if_elig;
    logic                w_d_elig;
    logic                w_grant_valid;
    logic                w_grant_id;
    logic                w_complete;
    logic                w_abort;
    logic                w_tmo_hit;

    // A requester sitting in its done cycle is not asking for a new access.
    assign w_if_elig = bus.if_req & ~r_if_done;
    assign w_d_elig  = bus.d_req & ~r_d_done;
    assign w_tmo_hit = (TIMEOUT > 0) && (r_tmo_cnt == TMO_LAST);

    always_comb begin
        w_next_state  = r_state;
        w_grant_valid = 1'b0;
        w_grant_id    = GNT_IF;
        w_complete    = 1'b0;
        w_abort       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_if_elig | w_d_elig) begin
                    w_grant_valid = 1'b1;
                    w_grant_id    = (w_d_elig & (~w_if_elig | (r_last_grant == GNT_IF))) ? GNT_D : GNT_IF;
                    w_next_state  = (w_grant_id == GNT_D) ? BUSY_D : BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (bus.mem_ready) begin
                    w_complete   = 1'b1;
                    w_next_state = IDLE;
                end else if (w_tmo_hit) begin
                    w_abort      = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= GNT_IF;
            r_tmo_cnt    <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_if_done    <= 1'b0;
            r_d_done     <= 1'b0;
            r_err        <= 1'b0;
            r_err_src    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            r_err     <= 1'b0;
            r_err_src <= 1'b0;
            if (w_grant_valid) begin
                r_mem_req    <= 1'b1;
                r_last_grant <= w_grant_id;
                r_tmo_cnt    <= '0;
                r_mem_addr   <= (w_grant_id == GNT_D) ? bus.d_addr : bus.if_addr;
                r_mem_we     <= (w_grant_id == GNT_D) & bus.d_we;
                r_mem_be     <= (w_grant_id == GNT_D) ? bus.d_be : '1;
                r_mem_wdata  <= (w_grant_id == GNT_D) ? bus.d_wdata : '0;
            end
            if (w_complete | w_abort) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                r_tmo_cnt <= '0;
                if (r_state == BUSY_IF) begin
                    r_if_done  <= 1'b1;
                    r_if_rdata <= w_complete ? bus.mem_rdata : '0;
                end else begin
                    r_d_done <= 1'b1;
                    if (w_abort)
                        r_d_rdata <= '0;
                    else if (!r_mem_we)
                        r_d_rdata <= bus.mem_rdata;
                end
                if (w_abort) begin
                    r_err     <= 1'b1;
                    r_err_src <= (r_state == BUSY_D);
                end
            end else if (r_state != IDLE) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.if_done   = r_if_done;
    assign bus.d_done    = r_d_done;
    assign bus.err       = r_err;
    assign bus.err_src   = r_err_src;
    assign bus.stall_if  = bus.if_req & ~r_if_done;
    assign bus.stall_d   = bus.d_req & ~r_d_done;

`ifdef ARB_PERF_CNT_EN
    arb_perf_counters u_perf (
        .clk         (clk),
        .reset       (reset),
        .i_if_done   (r_if_done),
        .i_d_done    (r_d_done),
        .i_stall     (bus.stall_if | bus.stall_d),
        .o_if_cnt    (perf_if_cnt),
        .o_d_cnt     (perf_d_cnt),
        .o_stall_cnt (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_mem_port_arbiter;
    import arb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TMO    = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perfIf;
    logic [31:0] perfD;
    logic [31:0] perfStall;
`endif

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ARB_PERF_CNT_EN
       ,.perf_if_cnt    (perfIf),
        .perf_d_cnt     (perfD),
        .perf_stall_cnt (perfStall)
`endif
    );

    int nChecks = 0;
    int nFail   = 0;

    // Model: who owns the memory (0 none, 1 fetch, 2 data), the captured transaction,
    // and the outputs that must be visible in the current cycle.
    bit          mValid = 1'b0;
    int          mOwner;
    int          mLast;
    int          mWait;
    logic [31:0] mAddr;
    logic [31:0] mWdata;
    logic        mWe;
    logic [3:0]  mBe;
    logic        eIfDone;
    logic        eDDone;
    logic        eErr;
    logic        eErrSrc;
    logic [31:0] eIfRdata;
    logic [31:0] eDRdata;
    logic [31:0] mIfCnt;
    logic [31:0] mDCnt;
    logic [31:0] mStallCnt;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareAll();
        if (!mValid) return;
        checkOutput("mem_req", bus.mem_req, mOwner != 0);
        if (mOwner != 0) begin
            checkOutput("mem_addr", bus.mem_addr, mAddr);
            checkOutput("mem_we", bus.mem_we, mWe);
            checkOutput("mem_be", bus.mem_be, mBe);
            if (mWe) checkOutput("mem_wdata", bus.mem_wdata, mWdata);
        end
        checkOutput("if_done", bus.if_done, eIfDone);
        checkOutput("d_done", bus.d_done, eDDone);
        checkOutput("err", bus.err, eErr);
        if (eErr) checkOutput("err_src", bus.err_src, eErrSrc);
        if (eIfDone) checkOutput("if_rdata", bus.if_rdata, eIfRdata);
        if (eDDone) checkOutput("d_rdata", bus.d_rdata, eDRdata);
        checkOutput("stall_if", bus.stall_if, bus.if_req && !eIfDone);
        checkOutput("stall_d", bus.stall_d, bus.d_req && !eDDone);
`ifdef ARB_PERF_CNT_EN
        checkOutput("perf_if_cnt", perfIf, mIfCnt);
        checkOutput("perf_d_cnt", perfD, mDCnt);
        checkOutput("perf_stall_cnt", perfStall, mStallCnt);
`endif
    endtask

    // Advance the model by one clock using the inputs held during this cycle.
    task automatic modelStep();
        logic nIfDone;
        logic nDDone;
        logic nErr;
        logic nErrSrc;
        bit   wantIf;
        bit   wantD;
        bit   finish;
        bit   abort;
        int   pick;
        nIfDone = 1'b0; nDDone = 1'b0; nErr = 1'b0; nErrSrc = 1'b0;
        finish = 1'b0; abort = 1'b0;
        if (reset) begin
            mIfCnt = 0; mDCnt = 0; mStallCnt = 0;
        end else begin
            if (eIfDone) mIfCnt++;
            if (eDDone) mDCnt++;
            if ((bus.if_req && !eIfDone) || (bus.d_req && !eDDone)) mStallCnt++;
        end
        if (reset) begin
            mOwner = 0; mLast = 1; mWait = 0;
            eIfRdata = 0; eDRdata = 0;
            mAddr = 0; mWdata = 0; mWe = 0; mBe = 0;
        end else if (mOwner == 0) begin
            wantIf = bus.if_req && !eIfDone;
            wantD  = bus.d_req && !eDDone;
            pick = 0;
            if (wantIf && wantD) pick = (mLast == 1) ? 2 : 1;
            else if (wantIf) pick = 1;
            else if (wantD) pick = 2;
            if (pick != 0) begin
                mOwner = pick; mLast = pick; mWait = 0;
                if (pick == 1) begin
                    mAddr = bus.if_addr; mWe = 1'b0; mBe = 4'hF; mWdata = 0;
                end else begin
                    mAddr = bus.d_addr; mWe = bus.d_we; mBe = bus.d_be; mWdata = bus.d_wdata;
                end
            end
        end else begin
            if (bus.mem_ready) begin
                finish = 1'b1;
            end else begin
                mWait++;
                if (TMO > 0 && mWait == TMO) begin
                    finish = 1'b1;
                    abort  = 1'b1;
                end
            end
        end
        if (finish) begin
            if (mOwner == 1) begin
                nIfDone  = 1'b1;
                eIfRdata = abort ? 32'h0 : bus.mem_rdata;
            end else begin
                nDDone = 1'b1;
                if (abort) eDRdata = 32'h0;
                else if (!mWe) eDRdata = bus.mem_rdata;
            end
            if (abort) begin
                nErr    = 1'b1;
                nErrSrc = (mOwner == 2);
            end
            mOwner = 0;
        end
        eIfDone = nIfDone; eDDone = nDDone; eErr = nErr; eErrSrc = nErrSrc;
        mValid = 1'b1;
    endtask

    // Inputs for this cycle are already driven; check, update model, move to next cycle.
    task automatic applyStimulus();
        #1;
        compareAll();
        modelStep();
        @(negedge clk);
    endtask

    task automatic randomCycle(input bit slow);
        if (bus.if_req) begin
            if (bus.if_done) begin
                if ($urandom_range(1, 0) == 0) bus.if_req = 1'b0;
                else bus.if_addr = $urandom & 32'hFFFF_FFFC;
            end else if ($urandom_range(15, 0) == 0) begin
                bus.if_req = 1'b0;
            end
        end else if ($urandom_range(1, 0) == 1) begin
            bus.if_req  = 1'b1;
            bus.if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (bus.d_req && !bus.d_done) begin
            if ($urandom_range(15, 0) == 0) bus.d_req = 1'b0;
        end else if (bus.d_req && $urandom_range(1, 0) == 0) begin
            bus.d_req = 1'b0;
        end else if ($urandom_range(1, 0) == 1) begin
            bus.d_req   = 1'b1;
            bus.d_we    = $urandom_range(1, 0);
            bus.d_be    = $urandom_range(15, 0);
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
        end
        bus.mem_ready = slow ? ($urandom_range(31, 0) == 0) : ($urandom_range(3, 0) != 0);
        bus.mem_rdata = $urandom;
        reset = ($urandom_range(299, 0) == 0);
        applyStimulus();
    endtask

    initial begin
        reset = 1'b1;
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_be = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_ready = 0;
        @(negedge clk);
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
        checkOutput("rst_mem_req", bus.mem_req, 0);
        checkOutput("rst_if_rdata", bus.if_rdata, 0);
        checkOutput("rst_d_rdata", bus.d_rdata, 0);
        checkOutput("rst_err", bus.err, 0);

        // Single fetch with an immediately ready memory
        bus.if_req = 1; bus.if_addr = 32'h4; bus.mem_ready = 1; bus.mem_rdata = 32'h0050_0093;
        #1 checkOutput("t1_stall_c0", bus.stall_if, 1);
        applyStimulus();
        checkOutput("t1_mem_req_c1", bus.mem_req, 1);
        checkOutput("t1_mem_addr_c1", bus.mem_addr, 32'h4);
        checkOutput("t1_stall_c1", bus.stall_if, 1);
        applyStimulus();
        checkOutput("t1_if_done_c2", bus.if_done, 1);
        checkOutput("t1_if_rdata_c2", bus.if_rdata, 32'h0050_0093);
        checkOutput("t1_stall_c2", bus.stall_if, 0);
        bus.if_req = 0;
        applyStimulus();

        // Tie straight after reset goes to data, then fetch follows
        reset = 1; applyStimulus(); reset = 0;
        bus.if_req = 1; bus.if_addr = 32'h8;
        bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h100; bus.mem_rdata = 32'h1111_1111;
        applyStimulus();
        checkOutput("t2_tie1_data_addr", bus.mem_addr, 32'h100);
        applyStimulus();
        checkOutput("t2_d_done", bus.d_done, 1);
        checkOutput("t2_d_rdata", bus.d_rdata, 32'h1111_1111);
        bus.d_req = 0; bus.mem_rdata = 32'h0000_0013;
        applyStimulus();
        checkOutput("t2_then_fetch_addr", bus.mem_addr, 32'h8);
        applyStimulus();
        checkOutput("t2_if_done", bus.if_done, 1);
        bus.if_req = 0;
        applyStimulus();
        bus.d_req = 1; bus.d_addr = 32'h104; bus.mem_rdata = 32'h2222_2222;
        applyStimulus();
        applyStimulus();
        checkOutput("t2_load_rdata", bus.d_rdata, 32'h2222_2222);
        bus.d_req = 0;
        applyStimulus();
        bus.if_req = 1; bus.if_addr = 32'hC; bus.d_req = 1; bus.d_addr = 32'h108; bus.mem_rdata = 32'h3333_3333;
        applyStimulus();
        checkOutput("t2_tie2_fetch_addr", bus.mem_addr, 32'hC);
        applyStimulus();
        bus.if_req = 0;
        applyStimulus();
        checkOutput("t2_tie2_data_addr", bus.mem_addr, 32'h108);
        applyStimulus();
        bus.d_req = 0;
        applyStimulus();

        // Store leaves d_rdata untouched
        bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011; bus.d_addr = 32'h100;
        bus.d_wdata = 32'hDEAD_BEEF; bus.mem_rdata = 32'h5555_5555;
        applyStimulus();
        checkOutput("t3_mem_we", bus.mem_we, 1);
        checkOutput("t3_mem_be", bus.mem_be, 32'h3);
        checkOutput("t3_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        applyStimulus();
        checkOutput("t3_d_done", bus.d_done, 1);
        checkOutput("t3_d_rdata_held", bus.d_rdata, 32'h3333_3333);
        bus.d_req = 0; bus.d_we = 0; bus.d_be = 4'hF;
        applyStimulus();

        // Hung load aborts after TMO busy cycles
        bus.d_req = 1; bus.d_addr = 32'h200; bus.mem_ready = 0;
        applyStimulus();
        for (int i = 0; i < TMO; i++) applyStimulus();
        checkOutput("t4_err", bus.err, 1);
        checkOutput("t4_err_src", bus.err_src, 1);
        checkOutput("t4_d_done", bus.d_done, 1);
        checkOutput("t4_d_rdata_zero", bus.d_rdata, 0);
        bus.d_req = 0;
        applyStimulus();
        // Ready arriving on the limit cycle wins over the abort
        bus.d_req = 1; bus.d_addr = 32'h204; bus.mem_rdata = 32'h4444_4444;
        applyStimulus();
        for (int i = 0; i < TMO - 1; i++) applyStimulus();
        bus.mem_ready = 1;
        applyStimulus();
        checkOutput("t4b_d_done", bus.d_done, 1);
        checkOutput("t4b_no_err", bus.err, 0);
        checkOutput("t4b_d_rdata", bus.d_rdata, 32'h4444_4444);
        bus.d_req = 0;
        applyStimulus();

        // Reset in the middle of a fetch
        bus.if_req = 1; bus.if_addr = 32'h40; bus.mem_ready = 0;
        applyStimulus();
        reset = 1;
        applyStimulus();
        checkOutput("t5_mem_req", bus.mem_req, 0);
        checkOutput("t5_if_done", bus.if_done, 0);
        checkOutput("t5_err", bus.err, 0);
        reset = 0; bus.if_req = 0;
        applyStimulus();
        checkOutput("t5_no_late_done", bus.if_done, 0);

`ifdef ARB_PERF_CNT_EN
        reset = 1; bus.mem_ready = 1; applyStimulus(); reset = 0;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin bus.if_req = 1; bus.if_addr = 32'(k * 4); end
            else begin bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'(32'h300 + k); end
            applyStimulus();
            applyStimulus();
            bus.if_req = 0; bus.d_req = 0;
            applyStimulus();
        end
        checkOutput("t6_perf_if", perfIf, 3);
        checkOutput("t6_perf_d", perfD, 2);
        checkOutput("t6_perf_stall", perfStall, 10);
`endif

        for (int c = 0; c < 3000; c++) randomCycle(((c / 400) % 3) == 2);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
